// File: rtl/bullet_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bullet_pkg
//  Purpose  : Shared definitions for the bullet scheduler: OAM word field
//             positions, screen geometry, direction and FSM state encodings,
//             and a helper that packs one OAM word.
//  Revision : 1.0 - initial release
// ============================================================================
package bullet_pkg;

    // OAM word field positions
    localparam int OWNER_LSB = 29;   // [31:29]
    localparam int EN_BIT    = 28;   // [28]
    localparam int X_LSB     = 18;   // [27:18]
    localparam int Y_LSB     = 8;    // [17:8]
    localparam int DIR_LSB   = 6;    // [7:6]
    localparam int ROW_LSB   = 3;    // [5:3]
    localparam int COL_LSB   = 0;    // [2:0]

    // Visible area and sprite size in pixels
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int TILE_SIZE = 8;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // Sprite row is always 0; sprite column selects the arrow for the direction.
    function automatic logic [31:0] make_oam_word(
        input logic [2:0] owner,
        input logic       en,
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [1:0] dir
    );
        return {owner, en, x, y, dir, 3'd0, 1'b0, dir};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bullet_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Purpose  : Combinational round-robin arbiter. Searches the eligible vector
//             starting at the pointer and returns the first hit.
//  Ports    : eligible [N]  requesters that may be granted this cycle
//             ptr      [PW] index where the search starts
//             grant    [N]  one-hot winner (zero when none eligible)
//             valid         a winner exists
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          valid
);

    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int off = 0; off < N; off++) begin
            if (!valid && eligible[(int'(ptr) + off) % N]) begin
                grant[(int'(ptr) + off) % N] = 1'b1;
                valid                        = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bullet_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : bullet_scheduler
//  Purpose  : Owns the bullet OAM table. Grants fire requests round-robin into
//             the lowest free slot, moves every live bullet once per frame in
//             a one-slot-per-cycle sweep, and retires bullets that leave the
//             screen or are reported hit.
//  Ports    : clk, rst_n (async, active-low)
//             frame_tick        start-of-vblank pulse, launches a sweep
//             fire_req/x/y/dir  per-requester fire request and spawn data
//             hit_clear         per-slot kill strobe
//             fire_grant        one-hot grant pulse
//             oam_data          OAM table for bullet_engine
//             busy              high while the sweep runs
//             active_count      number of enabled slots
//  Revision : 1.0 - initial release
// ============================================================================
module bullet_scheduler
    import bullet_pkg::*;
#(
    parameter int OAM_DEPTH   = 16,
    parameter int N_REQ       = 4,
    parameter int MAX_PER_REQ = 2,
    parameter int SPEED       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic [N_REQ-1:0]     fire_req,
    input  logic [N_REQ*10-1:0]  fire_x,
    input  logic [N_REQ*10-1:0]  fire_y,
    input  logic [N_REQ*2-1:0]   fire_dir,
    input  logic [OAM_DEPTH-1:0] hit_clear,
    output logic [N_REQ-1:0]     fire_grant,
    output logic [31:0]          oam_data [OAM_DEPTH],
    output logic                 busy,
    output logic [4:0]           active_count
);

    localparam int IW = $clog2(OAM_DEPTH);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_PER_REQ + 1);

    // Move limits, evaluated in 11 bits so a step can never wrap.
    localparam logic [10:0] C_SPEED  = 11'(SPEED);
    localparam logic [10:0] C_X_MAX  = 11'(SCREEN_W - TILE_SIZE);
    localparam logic [10:0] C_Y_MAX  = 11'(SCREEN_H - TILE_SIZE);

    state_t          r_state;
    logic [IW-1:0]   r_sweep_idx;
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt [N_REQ];

    logic [31:0]          w_oam_next [OAM_DEPTH];
    logic [CW-1:0]        w_cnt_next [N_REQ];
    logic [N_REQ-1:0]     w_grant_next;
    logic [PW-1:0]        w_ptr_next;
    logic [4:0]           w_active_next;
    logic [OAM_DEPTH-1:0] w_fall;
    logic                 w_free_found;
    logic [IW-1:0]        w_free_idx;
    logic [N_REQ-1:0]     w_eligible;
    logic [N_REQ-1:0]     w_arb_grant;
    logic                 w_arb_valid;
    logic [PW-1:0]        w_grant_idx;
    logic                 w_fire_ok;
    logic [31:0]          w_cur;
    logic [10:0]          w_mv_x;
    logic [10:0]          w_mv_y;
    logic                 w_mv_en;

    // Lowest free slot. A slot being hit this cycle is not offered, so a kill
    // and a fire write can never land on the same slot.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = OAM_DEPTH - 1; i >= 0; i--) begin
            if (!oam_data[i][EN_BIT] && !hit_clear[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            w_eligible[k] = fire_req[k] && (r_cnt[k] < CW'(MAX_PER_REQ)) && w_free_found;
        end
    end

    rr_arbiter #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_arbiter (
        .eligible (w_eligible),
        .ptr      (r_ptr),
        .grant    (w_arb_grant),
        .valid    (w_arb_valid)
    );

    always_comb begin
        w_grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_arb_grant[k]) w_grant_idx = PW'(k);
        end
    end

    // Move of the slot currently visited by the sweep.
    always_comb begin
        w_cur   = oam_data[r_sweep_idx];
        w_mv_x  = {1'b0, w_cur[X_LSB +: 10]};
        w_mv_y  = {1'b0, w_cur[Y_LSB +: 10]};
        w_mv_en = 1'b1;
        case (dir_t'(w_cur[DIR_LSB +: 2]))
            DIR_UP: begin
                if (w_mv_y < C_SPEED) w_mv_en = 1'b0;
                else                  w_mv_y  = w_mv_y - C_SPEED;
            end
            DIR_LEFT: begin
                if (w_mv_x < C_SPEED) w_mv_en = 1'b0;
                else                  w_mv_x  = w_mv_x - C_SPEED;
            end
            DIR_RIGHT: begin
                if (w_mv_x + C_SPEED > C_X_MAX) w_mv_en = 1'b0;
                else                            w_mv_x  = w_mv_x + C_SPEED;
            end
            default: begin
                if (w_mv_y + C_SPEED > C_Y_MAX) w_mv_en = 1'b0;
                else                            w_mv_y  = w_mv_y + C_SPEED;
            end
        endcase
    end

    // Next table: fire write (idle) or move (sweep), then kills on top.
    always_comb begin
        for (int i = 0; i < OAM_DEPTH; i++) w_oam_next[i] = oam_data[i];
        w_grant_next = '0;
        w_ptr_next   = r_ptr;
        w_fire_ok    = (r_state == ST_IDLE) && !frame_tick && w_arb_valid;

        if (w_fire_ok) begin
            w_oam_next[w_free_idx] = make_oam_word(3'(w_grant_idx), 1'b1,
                                                   fire_x[w_grant_idx*10 +: 10],
                                                   fire_y[w_grant_idx*10 +: 10],
                                                   fire_dir[w_grant_idx*2 +: 2]);
            w_grant_next = w_arb_grant;
            w_ptr_next   = (w_grant_idx == PW'(N_REQ - 1)) ? '0 : w_grant_idx + PW'(1);
        end

        if (r_state == ST_SWEEP && w_cur[EN_BIT]) begin
            w_oam_next[r_sweep_idx] = {w_cur[31:29], w_mv_en, w_mv_x[9:0], w_mv_y[9:0], w_cur[7:0]};
        end

        // Kill restores the old word with enable cleared, discarding any move.
        for (int i = 0; i < OAM_DEPTH; i++) begin
            if (hit_clear[i] && oam_data[i][EN_BIT]) begin
                w_oam_next[i]         = oam_data[i];
                w_oam_next[i][EN_BIT] = 1'b0;
            end
        end
    end

    // Owner bookkeeping: every 1->0 enable edge returns one credit.
    always_comb begin
        w_active_next = '0;
        for (int i = 0; i < OAM_DEPTH; i++) begin
            w_fall[i]     = oam_data[i][EN_BIT] & ~w_oam_next[i][EN_BIT];
            w_active_next = w_active_next + 5'(w_oam_next[i][EN_BIT]);
        end
        for (int k = 0; k < N_REQ; k++) begin
            w_cnt_next[k] = r_cnt[k] + CW'(w_grant_next[k]);
            for (int i = 0; i < OAM_DEPTH; i++) begin
                if (w_fall[i] && oam_data[i][OWNER_LSB +: 3] == 3'(k)) begin
                    w_cnt_next[k] = w_cnt_next[k] - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sweep_idx  <= '0;
            r_ptr        <= '0;
            busy         <= 1'b0;
            fire_grant   <= '0;
            active_count <= '0;
            for (int i = 0; i < OAM_DEPTH; i++) oam_data[i] <= '0;
            for (int k = 0; k < N_REQ; k++)     r_cnt[k]    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        r_state     <= ST_SWEEP;
                        r_sweep_idx <= '0;
                        busy        <= 1'b1;
                    end
                end
                default: begin
                    if (r_sweep_idx == IW'(OAM_DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_sweep_idx <= r_sweep_idx + IW'(1);
                    end
                end
            endcase
            r_ptr        <= w_ptr_next;
            fire_grant   <= w_grant_next;
            active_count <= w_active_next;
            for (int i = 0; i < OAM_DEPTH; i++) oam_data[i] <= w_oam_next[i];
            for (int k = 0; k < N_REQ; k++)     r_cnt[k]    <= w_cnt_next[k];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bullet_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bullet_scheduler
//  Purpose  : Self-checking bench for bullet_scheduler. Expected grants are
//             queued as stimulus is driven and compared as grants appear;
//             table contents are compared against hand-derived words.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bullet_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_tick;
    logic [3:0]  fire_req;
    logic [39:0] fire_x;
    logic [39:0] fire_y;
    logic [7:0]  fire_dir;
    logic [15:0] hit_clear;
    logic [3:0]  fire_grant;
    logic [31:0] oam_data [16];
    logic        busy;
    logic [4:0]  active_count;

    int checks   = 0;
    int failures = 0;
    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    bullet_scheduler #(
        .OAM_DEPTH   (16),
        .N_REQ       (4),
        .MAX_PER_REQ (2),
        .SPEED       (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .fire_req     (fire_req),
        .fire_x       (fire_x),
        .fire_y       (fire_y),
        .fire_dir     (fire_dir),
        .hit_clear    (hit_clear),
        .fire_grant   (fire_grant),
        .oam_data     (oam_data),
        .busy         (busy),
        .active_count (active_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input int owner, input bit en, input int x,
                                         input int y, input int d);
        logic [31:0] w;
        w        = '0;
        w[31:29] = owner[2:0];
        w[28]    = en;
        w[27:18] = x[9:0];
        w[17:8]  = y[9:0];
        w[7:6]   = d[1:0];
        w[2:0]   = {1'b0, d[1:0]};
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input int x, input int y, input int d);
        fire_x[k*10 +: 10] = x[9:0];
        fire_y[k*10 +: 10] = y[9:0];
        fire_dir[k*2 +: 2] = d[1:0];
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        fire_req   = '0;
        hit_clear  = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Pulses frame_tick, then counts busy cycles (bounded).
    task automatic run_sweep(output int n);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    // Scoreboard: every grant pulse must match the next queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (fire_grant !== 4'b0000) begin
                if (exp_q.size() == 0) check_eq("grant_unexpected", {28'd0, fire_grant}, 32'd0);
                else                   check_eq("grant_order", {28'd0, fire_grant}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        fire_x   = '0;
        fire_y   = '0;
        fire_dir = '0;

        // ---- reset state ----
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        fire_req   = '0;
        hit_clear  = '0;
        repeat (2) tick();
        check_eq("rst_oam0",   oam_data[0], 32'd0);
        check_eq("rst_oam15",  oam_data[15], 32'd0);
        check_eq("rst_busy",   {31'd0, busy}, 32'd0);
        check_eq("rst_active", {27'd0, active_count}, 32'd0);
        check_eq("rst_grant",  {28'd0, fire_grant}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ---- single fire, one-cycle latency ----
        set_req(0, 100, 200, 1);
        fire_req = 4'b0001;
        exp_q.push_back(4'b0001);
        tick();
        check_eq("grant_latency", {28'd0, fire_grant}, 32'd1);
        fire_req = 4'b0000;
        check_eq("first_word", oam_data[0], {3'd0, 1'b1, 10'd100, 10'd200, 2'd1, 3'd0, 3'd1});
        check_eq("first_active", {27'd0, active_count}, 32'd1);
        tick();
        check_eq("grant_pulse", {28'd0, fire_grant}, 32'd0);
        check_eq("q_empty_t1", exp_q.size(), 32'd0);

        // ---- round robin with per-owner cap ----
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 200 + 10*k, 50, 2);
        fire_req = 4'b1111;
        for (int r = 0; r < 2; r++) for (int k = 0; k < 4; k++) exp_q.push_back(4'b0001 << k);
        repeat (12) tick();
        fire_req = 4'b0000;
        for (int j = 0; j < 8; j++) check_eq($sformatf("rr_slot%0d", j), oam_data[j], word(j % 4, 1, 200 + 10*(j % 4), 50, 2));
        check_eq("rr_slot8_free", oam_data[8], 32'd0);
        check_eq("rr_active", {27'd0, active_count}, 32'd8);
        check_eq("q_empty_t2", exp_q.size(), 32'd0);

        // ---- off-screen right retires and returns credit ----
        do_reset();
        set_req(0, 630, 100, 1);
        fire_req = 4'b0001;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0001);
        repeat (4) tick();
        check_eq("cap_slot1", oam_data[1], word(0, 1, 630, 100, 1));
        check_eq("cap_active", {27'd0, active_count}, 32'd2);
        exp_q.push_back(4'b0001);
        run_sweep(n);
        check_eq("busy_cycles", n, 32'd16);
        check_eq("no_grant_in_sweep", {28'd0, fire_grant}, 32'd0);
        tick();
        check_eq("grant_after_free", {28'd0, fire_grant}, 32'd1);
        fire_req = 4'b0000;
        check_eq("right_new", oam_data[0], word(0, 1, 630, 100, 1));
        check_eq("right_gone", oam_data[1], word(0, 0, 630, 100, 1));
        check_eq("right_active", {27'd0, active_count}, 32'd1);
        check_eq("q_empty_t3", exp_q.size(), 32'd0);

        // ---- up edge, no wrap; frame_tick beats a same-cycle request ----
        do_reset();
        set_req(1, 50, 3, 0);
        fire_req = 4'b0010;
        exp_q.push_back(4'b0010);
        tick();
        set_req(2, 60, 4, 0);
        fire_req = 4'b0100;
        exp_q.push_back(4'b0100);
        tick();
        fire_req = 4'b0000;
        set_req(3, 300, 300, 3);
        fire_req = 4'b1000;
        exp_q.push_back(4'b1000);
        run_sweep(n);
        check_eq("busy_cycles2", n, 32'd16);
        check_eq("tick_priority", {28'd0, fire_grant}, 32'd0);
        tick();
        check_eq("grant_post_sweep", {28'd0, fire_grant}, 32'd8);
        fire_req = 4'b0000;
        check_eq("up_y3_off", oam_data[1 - 1], word(3, 1, 300, 300, 3));
        check_eq("up_y4_zero", oam_data[1], word(2, 1, 60, 0, 0));
        check_eq("up_active", {27'd0, active_count}, 32'd2);
        check_eq("q_empty_t4", exp_q.size(), 32'd0);

        // ---- hit during the visit of slot 5 ----
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 100 + 40*k, 100, 2);
        fire_req = 4'b1111;
        for (int j = 0; j < 6; j++) exp_q.push_back(4'b0001 << (j % 4));
        repeat (6) tick();
        fire_req = 4'b0000;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        repeat (5) tick();
        hit_clear = 16'h0020;
        tick();
        hit_clear = 16'h0000;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check_eq("hit_slot5", oam_data[5], word(1, 0, 140, 100, 2));
        check_eq("hit_slot4_moved", oam_data[4], word(0, 1, 100, 104, 2));
        check_eq("hit_slot0_moved", oam_data[0], word(0, 1, 100, 104, 2));
        check_eq("hit_active", {27'd0, active_count}, 32'd5);
        set_req(1, 140, 100, 2);
        fire_req = 4'b0010;
        exp_q.push_back(4'b0010);
        repeat (4) tick();
        fire_req = 4'b0000;
        check_eq("hit_refill", oam_data[5], word(1, 1, 140, 100, 2));
        check_eq("hit_refill_active", {27'd0, active_count}, 32'd6);
        check_eq("q_empty_t5", exp_q.size(), 32'd0);

        // ---- asynchronous reset mid-sweep ----
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        repeat (3) tick();
        check_eq("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #2;
        check_eq("arst_busy",   {31'd0, busy}, 32'd0);
        check_eq("arst_active", {27'd0, active_count}, 32'd0);
        check_eq("arst_oam0",   oam_data[0], 32'd0);
        check_eq("arst_oam5",   oam_data[5], 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check_eq("arst_aborted", {31'd0, busy}, 32'd0);
        check_eq("q_empty_end", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bullet_scheduler.md
Name: bullet_scheduler

Overview:
- Owns the bullet OAM table consumed by bullet_engine.
- Arbitrates fire requests from up to N_REQ tanks, round-robin, and allocates a free OAM slot per accepted shot.
- Advances every live bullet once per frame, and retires bullets that leave the screen or are reported hit.
- Sits between the game-logic and tank controllers on one side and bullet_engine on the other; its oam_data output connects directly to bullet_engine.oam_data.

Parameters:
- OAM_DEPTH, 16: number of bullet slots; matches bullet_engine.
- N_REQ, 4: number of fire requesters (max 8; owner field is 3 bits).
- MAX_PER_REQ, 2: maximum live bullets per requester.
- SPEED, 4: pixels moved per frame_tick.
- SCREEN_W, 640; SCREEN_H, 480: visible area in pixels.
- TILE_SIZE, 8: bullet edge length in pixels.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- frame_tick  in  1  one-cycle pulse at start of vblank
- fire_req  in  N_REQ  per-requester fire request, level, held until granted
- fire_x  in  N_REQ*10  spawn X per requester, packed, requester k at [10k+9:10k]
- fire_y  in  N_REQ*10  spawn Y per requester, packed
- fire_dir  in  N_REQ*2  direction per requester: 0 up, 1 right, 2 down, 3 left
- hit_clear  in  OAM_DEPTH  per-slot kill strobe from collision logic
- fire_grant  out  N_REQ  one-hot, one-cycle grant pulse
- oam_data  out  [31:0] x OAM_DEPTH  OAM table, unpacked array
- busy  out  1  high while the move sweep runs
- active_count  out  5  number of enabled slots

Behaviour:
- OAM word layout:
  - [31:29] owner id
  - [28] enable
  - [27:18] pos_x
  - [17:8] pos_y
  - [7:6] dir
  - [5:3] sprite row = 0
  - [2:0] sprite col = {1'b0, dir}
- Reset: all oam_data = 0, fire_grant = 0, busy = 0, active_count = 0, round-robin pointer = 0, per-owner counters = 0, state = IDLE.
- Reset asserted mid-sweep aborts the sweep immediately.
- FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP on frame_tick.
  - SWEEP visits slot index 0..OAM_DEPTH-1, one slot per cycle. busy = 1 for exactly OAM_DEPTH cycles.
  - SWEEP -> IDLE after the last slot.
- Fire handling (IDLE only, and not on a frame_tick cycle, since frame_tick has priority):
  - Eligible requester: fire_req high, its owner count < MAX_PER_REQ, and at least one free slot exists.
  - Round-robin arbiter picks one eligible requester, starting the search at the pointer.
  - On the next clock edge:
    - write the lowest-index free slot: enable = 1, owner, pos, dir;
    - pulse fire_grant[k] for 1 cycle;
    - increment the owner count;
    - set the pointer to k+1 (mod N_REQ).
  - Requests that are ineligible stay pending with no grant.
  - At most one grant per cycle. Grant latency is 1 cycle after an eligible cycle in IDLE.
- Move, per visited enabled slot, with arithmetic in 11 bits and no wrap:
  - up: if y < SPEED, disable; else y -= SPEED.
  - left: if x < SPEED, disable; else x -= SPEED.
  - right: if x + SPEED > SCREEN_W - TILE_SIZE, disable; else x += SPEED.
  - down: if y + SPEED > SCREEN_H - TILE_SIZE, disable; else y += SPEED.
  - Disabled slots are skipped, with no change.
- Kill: hit_clear[i] is honoured every cycle in any state and clears enable of slot i.
  - It has priority over a move or a fire write to the same slot in that cycle.
  - hit_clear on an already disabled slot does nothing.
- Every enable 1->0 transition (kill or off-screen) decrements that owner's count exactly once.
- frame_tick during SWEEP is ignored.
- A slot freed in cycle t is allocatable from cycle t+1.
- Table full (all slots enabled): no grants; requests remain pending.
- active_count is registered and equals the popcount of enable bits.

Decomposition:
- Shared package bullet_pkg holds:
  - OAM field bit positions;
  - dir_t enum (UP, RIGHT, DOWN, LEFT);
  - SCREEN_W, SCREEN_H, TILE_SIZE constants;
  - fsm state enum.
- One natural sub-module: rr_arbiter, which takes the eligible vector and the pointer and produces a one-hot grant plus a valid flag.
- Free-slot priority encoder stays inline.

Test Plan:
- Reset, then fire_req[0] with x=100, y=200, dir=1 -> fire_grant[0] pulses 1 cycle later; oam_data[0] = {3'd0, 1, 100, 200, 2'd1, 3'd0, 3'd1}; active_count = 1.
- fire_req = 4'b1111 held continuously -> grants in order 0, 1, 2, 3, 0, 1, 2, 3; then no further grants since MAX_PER_REQ = 2; slots 0..7 filled; active_count = 8.
- Bullet at x=630, dir right, then frame_tick -> busy high for 16 cycles; slot disabled (634 > 632); owner count drops; the next request from that owner is granted.
- Bullet at y=3, dir up, plus frame_tick -> disabled, with no wrap to 1023. Bullet at y=4 -> y=0, stays enabled.
- hit_clear[5] in the same cycle the sweep visits slot 5 -> slot 5 disabled, no position update; owner count decremented exactly once.
- frame_tick and fire_req on the same cycle -> sweep runs first; grant issued on the first IDLE cycle after busy falls. rst_n low mid-sweep -> all outputs zero asynchronously.
